// File: rtl/elevator_scan_ctrl_if.sv
// Button inputs and status outputs of the elevator controller core.
// The panel side (master) drives the buttons and observes the status.
// The controller side (slave) samples the buttons and drives the status.
interface elevator_scan_ctrl_if #(
  parameter int unsigned FLOORS     = 8,
  parameter int unsigned DOOR_TICKS = 5
);
  localparam int unsigned CNT_W = $clog2(DOOR_TICKS + 1);

  // Buttons
  logic [FLOORS-1:0] btup;
  logic [FLOORS-1:0] btdn;
  logic [FLOORS-1:0] in_bt_floor;
  logic              bt_door_open;
  logic              bt_door_close;

  // Status towards display decoders and LEDs
  logic [FLOORS-1:0] floor;
  logic [1:0]        state;
  logic              led_state_up;
  logic              led_state_dn;
  logic              door_open;
  logic [CNT_W-1:0]  cnt;
  logic [FLOORS-1:0] pend_up;
  logic [FLOORS-1:0] pend_dn;
  logic [FLOORS-1:0] pend_car;

  modport master (
    output btup, btdn, in_bt_floor, bt_door_open, bt_door_close,
    input  floor, state, led_state_up, led_state_dn, door_open, cnt,
    input  pend_up, pend_dn, pend_car
  );

  modport slave (
    input  btup, btdn, in_bt_floor, bt_door_open, bt_door_close,
    output floor, state, led_state_up, led_state_dn, door_open, cnt,
    output pend_up, pend_dn, pend_car
  );
endinterface

// File: rtl/elevator_scan_ctrl.sv
// Parametrised SCAN elevator controller core.
// Latches hall and cabin calls every clock; all motion and door timing
// advances only on cycles where the external time-base enable tick is high.
module elevator_scan_ctrl #(
  parameter int unsigned FLOORS     = 8,
  parameter int unsigned DOOR_TICKS = 5,
  parameter int unsigned MOVE_TICKS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  elevator_scan_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(DOOR_TICKS + 1);
  localparam int unsigned MV_W  = (MOVE_TICKS > 1) ? $clog2(MOVE_TICKS) : 1;

  // Top floor has no up-call, bottom floor has no down-call.
  localparam logic [FLOORS-1:0] UpMask = {1'b0, {(FLOORS-1){1'b1}}};
  localparam logic [FLOORS-1:0] DnMask = {{(FLOORS-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StMoveUp = 2'b01,
    StMoveDn = 2'b10,
    StDoor   = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [FLOORS-1:0] floor_q, floor_d;
  logic              dir_up_q, dir_up_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MV_W-1:0]   mv_q, mv_d;
  logic [FLOORS-1:0] pend_up_q, pend_up_d;
  logic [FLOORS-1:0] pend_dn_q, pend_dn_d;
  logic [FLOORS-1:0] pend_car_q, pend_car_d;
  logic              reopen_q, reopen_d;
  logic              led_up_q, led_up_d;
  logic              led_dn_q, led_dn_d;
  logic              door_open_q, door_open_d;

  logic [FLOORS-1:0] req_up, req_dn, req_car;
  logic [FLOORS-1:0] pend_all;
  logic [FLOORS-1:0] fl_sh, above_mask, below_mask;
  logic              any_above, any_below, any_here;
  logic              here_press;
  logic [FLOORS-1:0] floor_nx, nx_sh, nx_above, nx_below, beyond;
  logic [FLOORS-1:0] hall_fwd, hall_rev;
  logic              stop_nx;
  logic              door_exit;
  logic              open_req;
  logic [FLOORS-1:0] clr_mask;

  assign req_up  = bus.btup & UpMask;
  assign req_dn  = bus.btdn & DnMask;
  assign req_car = bus.in_bt_floor;

  assign pend_all = pend_up_q | pend_dn_q | pend_car_q;

  // One-hot floor f: (f << 1) - 1 covers f and everything below it.
  assign fl_sh      = floor_q << 1;
  assign above_mask = ~(fl_sh - FLOORS'(1));
  assign below_mask = floor_q - FLOORS'(1);

  assign any_above = |(pend_all & above_mask);
  assign any_below = |(pend_all & below_mask);
  assign any_here  = |(pend_all & floor_q);

  // A press for the floor the door is open at restarts the dwell instead of latching.
  assign here_press = |((req_up | req_dn | req_car) & floor_q);

  // Candidate floor after one step in the current travel direction, saturating at the ends.
  always_comb begin
    floor_nx = floor_q;
    if (state_q == StMoveUp) begin
      if (!floor_q[FLOORS-1]) floor_nx = floor_q << 1;
    end else if (state_q == StMoveDn) begin
      if (!floor_q[0]) floor_nx = floor_q >> 1;
    end
  end

  assign nx_sh    = floor_nx << 1;
  assign nx_above = ~(nx_sh - FLOORS'(1));
  assign nx_below = floor_nx - FLOORS'(1);

  // Arrival decision on the candidate floor: cabin call, same-direction hall call,
  // or opposite hall call when nothing remains further along.
  always_comb begin
    hall_fwd = pend_up_q;
    hall_rev = pend_dn_q;
    beyond   = nx_above;
    if (state_q == StMoveDn) begin
      hall_fwd = pend_dn_q;
      hall_rev = pend_up_q;
      beyond   = nx_below;
    end
    stop_nx = (|(pend_car_q & floor_nx)) ||
              (|(hall_fwd & floor_nx)) ||
              ((|(hall_rev & floor_nx)) && !(|(pend_all & beyond)));
  end

  // SCAN state machine: next state, floor, direction and counters.
  always_comb begin
    state_d   = state_q;
    floor_d   = floor_q;
    dir_up_d  = dir_up_q;
    cnt_d     = cnt_q;
    mv_d      = mv_q;
    door_exit = 1'b0;
    open_req  = bus.bt_door_open || reopen_q || here_press;

    if (tick) begin
      unique case (state_q)
        StIdle: begin
          if (any_here || bus.bt_door_open) begin
            state_d = StDoor;
            cnt_d   = '0;
          end else if (any_above) begin
            state_d  = StMoveUp;
            dir_up_d = 1'b1;
            mv_d     = '0;
          end else if (any_below) begin
            state_d  = StMoveDn;
            dir_up_d = 1'b0;
            mv_d     = '0;
          end
        end

        StMoveUp, StMoveDn: begin
          if (mv_q == MV_W'(MOVE_TICKS - 1)) begin
            mv_d    = '0;
            floor_d = floor_nx;
            if (stop_nx) begin
              state_d = StDoor;
              cnt_d   = '0;
            end
          end else begin
            mv_d = mv_q + 1'b1;
          end
        end

        StDoor: begin
          // Close beats open; open beats the dwell timeout.
          if (bus.bt_door_close) begin
            door_exit = 1'b1;
          end else if (open_req) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_W'(DOOR_TICKS - 1)) begin
            door_exit = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end

        default: state_d = StIdle;
      endcase

      if (door_exit) begin
        cnt_d = '0;
        mv_d  = '0;
        if (dir_up_q ? any_above : any_below) begin
          state_d = dir_up_q ? StMoveUp : StMoveDn;
        end else if (dir_up_q ? any_below : any_above) begin
          state_d  = dir_up_q ? StMoveDn : StMoveUp;
          dir_up_d = !dir_up_q;
        end else begin
          state_d = StIdle;
        end
      end
    end
  end

  // Request latching every clock; the floor the door is open at is always cleared.
  always_comb begin
    clr_mask   = (state_d == StDoor) ? floor_d : '0;
    pend_up_d  = (pend_up_q | req_up) & ~clr_mask;
    pend_dn_d  = (pend_dn_q | req_dn) & ~clr_mask;
    pend_car_d = (pend_car_q | req_car) & ~clr_mask;

    // Remember an at-floor press until the next tick consumes it.
    if (tick) reopen_d = 1'b0;
    else      reopen_d = reopen_q || (here_press && (state_q == StDoor));

    led_up_d    = (state_d == StMoveUp);
    led_dn_d    = (state_d == StMoveDn);
    door_open_d = (state_d == StDoor);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      floor_q     <= FLOORS'(1);
      dir_up_q    <= 1'b1;
      cnt_q       <= '0;
      mv_q        <= '0;
      pend_up_q   <= '0;
      pend_dn_q   <= '0;
      pend_car_q  <= '0;
      reopen_q    <= 1'b0;
      led_up_q    <= 1'b0;
      led_dn_q    <= 1'b0;
      door_open_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      floor_q     <= floor_d;
      dir_up_q    <= dir_up_d;
      cnt_q       <= cnt_d;
      mv_q        <= mv_d;
      pend_up_q   <= pend_up_d;
      pend_dn_q   <= pend_dn_d;
      pend_car_q  <= pend_car_d;
      reopen_q    <= reopen_d;
      led_up_q    <= led_up_d;
      led_dn_q    <= led_dn_d;
      door_open_q <= door_open_d;
    end
  end

  assign bus.floor        = floor_q;
  assign bus.state        = state_q;
  assign bus.led_state_up = led_up_q;
  assign bus.led_state_dn = led_dn_q;
  assign bus.door_open    = door_open_q;
  assign bus.cnt          = cnt_q;
  assign bus.pend_up      = pend_up_q;
  assign bus.pend_dn      = pend_dn_q;
  assign bus.pend_car     = pend_car_q;

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Scoreboard bench for elevator_scan_ctrl (8 floors, 5 dwell ticks, 2 ticks per floor).
// Stimulus queues the expected status after each tick; a monitor checks it.
module tb_elevator_scan_ctrl;
  localparam int unsigned FLOORS     = 8;
  localparam int unsigned DOOR_TICKS = 5;
  localparam int unsigned MOVE_TICKS = 2;

  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic tick = 1'b0;

  elevator_scan_ctrl_if #(.FLOORS(FLOORS), .DOOR_TICKS(DOOR_TICKS)) bus ();

  elevator_scan_ctrl #(
    .FLOORS    (FLOORS),
    .DOOR_TICKS(DOOR_TICKS),
    .MOVE_TICKS(MOVE_TICKS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tick(tick),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at_ev;
    int         tag;
    logic [7:0] floor;
    logic [1:0] state;
    logic [2:0] cnt;
    logic [7:0] pu;
    logic [7:0] pd;
    logic [7:0] pc;
  } exp_t;

  exp_t sb[$];
  int   n_run    = 0;
  int   n_fail   = 0;
  int   n_issued = 0;
  int   ev_cnt   = 0;
  int   tag_n    = 0;

  // Count clock edges at which the DUT may change state.
  always @(posedge clk) if (tick || rst) ev_cnt <= ev_cnt + 1;

  task automatic chk(input string nm, input int tag, input logic [31:0] act,
                     input logic [31:0] want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s chk%0d: got %0h want %0h", nm, tag, act, want);
    end
  endtask

  // Monitor: compare DUT status against the expectation due at this event.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].at_ev <= ev_cnt) begin
      e = sb.pop_front();
      if (e.at_ev < ev_cnt) begin
        n_run++;
        n_fail++;
        $display("FAIL late chk%0d: got event %0d want %0d", e.tag, ev_cnt, e.at_ev);
      end else begin
        chk("floor",    e.tag, 32'(bus.floor),        32'(e.floor));
        chk("state",    e.tag, 32'(bus.state),        32'(e.state));
        chk("cnt",      e.tag, 32'(bus.cnt),          32'(e.cnt));
        chk("pend_up",  e.tag, 32'(bus.pend_up),      32'(e.pu));
        chk("pend_dn",  e.tag, 32'(bus.pend_dn),      32'(e.pd));
        chk("pend_car", e.tag, 32'(bus.pend_car),     32'(e.pc));
        chk("led_up",   e.tag, 32'(bus.led_state_up), 32'(e.state == 2'b01));
        chk("led_dn",   e.tag, 32'(bus.led_state_dn), 32'(e.state == 2'b10));
        chk("door",     e.tag, 32'(bus.door_open),    32'(e.state == 2'b11));
      end
    end
  end

  // Expected status after the next tick/reset event.
  task automatic ex(input int fl, input logic [1:0] st, input int c,
                    input logic [7:0] pu, input logic [7:0] pd, input logic [7:0] pc);
    exp_t e;
    tag_n   = tag_n + 1;
    e.at_ev = n_issued + 1;
    e.tag   = tag_n;
    e.floor = 8'd1 << (fl - 1);
    e.state = st;
    e.cnt   = 3'(c);
    e.pu    = pu;
    e.pd    = pd;
    e.pc    = pc;
    sb.push_back(e);
  endtask

  // One tick period of 4 clocks, with door buttons / reset held during the tick clock.
  task automatic tk_b(input logic o, input logic c, input logic r);
    @(posedge clk); #1;
    tick = 1'b1;
    bus.bt_door_open  = o;
    bus.bt_door_close = c;
    rst  = r;
    n_issued++;
    @(posedge clk); #1;
    tick = 1'b0;
    bus.bt_door_open  = 1'b0;
    bus.bt_door_close = 1'b0;
    rst  = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic tk;
    tk_b(1'b0, 1'b0, 1'b0);
  endtask

  // One-clock button press between ticks.
  task automatic press(input logic [7:0] u, input logic [7:0] d, input logic [7:0] c);
    @(posedge clk); #1;
    bus.btup = u;
    bus.btdn = d;
    bus.in_bt_floor = c;
    @(posedge clk); #1;
    bus.btup = '0;
    bus.btdn = '0;
    bus.in_bt_floor = '0;
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout want finish");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    bus.btup = '0;
    bus.btdn = '0;
    bus.in_bt_floor = '0;
    bus.bt_door_open = 1'b0;
    bus.bt_door_close = 1'b0;

    // Reset, then cabin call to floor 3 from floor 1.
    ex(1, 2'b00, 0, 8'h00, 8'h00, 8'h00); tk_b(1'b0, 1'b0, 1'b1);
    press(8'h00, 8'h00, 8'h04);
    ex(1, 2'b01, 0, 8'h00, 8'h00, 8'h04); tk;
    tk;
    ex(2, 2'b01, 0, 8'h00, 8'h00, 8'h04); tk;
    tk;
    ex(3, 2'b11, 0, 8'h00, 8'h00, 8'h00); tk;
    ex(3, 2'b11, 1, 8'h00, 8'h00, 8'h00); tk;
    tk; tk;
    ex(3, 2'b11, 4, 8'h00, 8'h00, 8'h00); tk;
    ex(3, 2'b00, 0, 8'h00, 8'h00, 8'h00); tk;

    // Down-call at 5 and cabin call to 7: pass 5, serve 7, reverse, serve 5.
    ex(1, 2'b00, 0, 8'h00, 8'h00, 8'h00); tk_b(1'b0, 1'b0, 1'b1);
    press(8'h00, 8'h10, 8'h40);
    ex(1, 2'b01, 0, 8'h00, 8'h10, 8'h40); tk;
    repeat (7) tk;
    ex(5, 2'b01, 0, 8'h00, 8'h10, 8'h40); tk;
    repeat (3) tk;
    ex(7, 2'b11, 0, 8'h00, 8'h10, 8'h00); tk;
    repeat (4) tk;
    ex(7, 2'b10, 0, 8'h00, 8'h10, 8'h00); tk;
    ex(7, 2'b10, 0, 8'h00, 8'h10, 8'h00); tk;
    ex(6, 2'b10, 0, 8'h00, 8'h10, 8'h00); tk;
    tk;
    ex(5, 2'b11, 0, 8'h00, 8'h00, 8'h00); tk;
    repeat (4) tk;
    ex(5, 2'b00, 0, 8'h00, 8'h00, 8'h00); tk;

    // Go down to 3, then door-open at cnt=3 restarts the dwell.
    press(8'h00, 8'h00, 8'h04);
    ex(5, 2'b10, 0, 8'h00, 8'h00, 8'h04); tk;
    tk;
    ex(4, 2'b10, 0, 8'h00, 8'h00, 8'h04); tk;
    tk;
    ex(3, 2'b11, 0, 8'h00, 8'h00, 8'h00); tk;
    tk; tk;
    ex(3, 2'b11, 3, 8'h00, 8'h00, 8'h00); tk;
    ex(3, 2'b11, 0, 8'h00, 8'h00, 8'h00); tk_b(1'b1, 1'b0, 1'b0);
    repeat (3) tk;
    ex(3, 2'b11, 4, 8'h00, 8'h00, 8'h00); tk;
    ex(3, 2'b00, 0, 8'h00, 8'h00, 8'h00); tk;

    // Door opened from IDLE, closed on its first DOOR tick.
    ex(3, 2'b11, 0, 8'h00, 8'h00, 8'h00); tk_b(1'b1, 1'b0, 1'b0);
    ex(3, 2'b00, 0, 8'h00, 8'h00, 8'h00); tk_b(1'b0, 1'b1, 1'b0);

    // At-floor hall call re-opens; top up-call and bottom down-call are ignored.
    ex(3, 2'b11, 0, 8'h00, 8'h00, 8'h00); tk_b(1'b1, 1'b0, 1'b0);
    tk;
    ex(3, 2'b11, 2, 8'h00, 8'h00, 8'h00); tk;
    press(8'h04, 8'h00, 8'h00);
    ex(3, 2'b11, 0, 8'h00, 8'h00, 8'h00); tk;
    press(8'h80, 8'h01, 8'h00);
    ex(3, 2'b11, 1, 8'h00, 8'h00, 8'h00); tk;
    ex(3, 2'b00, 0, 8'h00, 8'h00, 8'h00); tk_b(1'b0, 1'b1, 1'b0);

    // Reset while moving up at floor 4, with tick high.
    press(8'h00, 8'h00, 8'h80);
    ex(3, 2'b01, 0, 8'h00, 8'h00, 8'h80); tk;
    tk;
    ex(4, 2'b01, 0, 8'h00, 8'h00, 8'h80); tk;
    ex(1, 2'b00, 0, 8'h00, 8'h00, 8'h00); tk_b(1'b0, 1'b0, 1'b1);
    ex(1, 2'b00, 0, 8'h00, 8'h00, 8'h00); tk;

    repeat (4) @(posedge clk);
    if (sb.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain: got %0d pending want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
- Parametrised elevator controller core for N floors, serving as the successor to the fixed 8-floor controller.
- Latches hall up/down calls and cabin calls, and schedules them with SCAN: keep the current direction while requests remain ahead, then reverse.
- Times floor travel and door dwell from an external time-base enable `tick`, not a derived clock.
- Exposes the current floor, the pending-request vectors and the state for the floor/counter display decoders and LEDs.

Parameters:
- FLOORS, default 8: number of floors, minimum 2. Floor k (1-based) maps to bit k-1.
- DOOR_TICKS, default 5: tick periods the door stays open, minimum 2.
- MOVE_TICKS, default 2: tick periods to travel one floor, minimum 1.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous reset, active-high.
- tick, input, 1: time-base enable, a one-clk pulse; all timing and state transitions advance only on cycles with tick=1.
- btup, input, FLOORS: hall up-call per floor. The top-floor bit is ignored.
- btdn, input, FLOORS: hall down-call per floor. Bit 0 is ignored.
- in_bt_floor, input, FLOORS: cabin floor buttons.
- bt_door_open, input, 1: cabin door-open button.
- bt_door_close, input, 1: cabin door-close button.
- floor, output, FLOORS: one-hot current floor.
- state, output, 2: 00 IDLE, 01 MOVE_UP, 10 MOVE_DN, 11 DOOR.
- led_state_up, output, 1: high when state is MOVE_UP.
- led_state_dn, output, 1: high when state is MOVE_DN.
- door_open, output, 1: high when state is DOOR.
- cnt, output, $clog2(DOOR_TICKS+1): door dwell counter.
- pend_up, output, FLOORS: latched hall up-calls.
- pend_dn, output, FLOORS: latched hall down-calls.
- pend_car, output, FLOORS: latched cabin calls.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge; overrides tick and all buttons):
  - floor = 1 (bit 0), state = IDLE, dir = up.
  - cnt = 0, internal move counter = 0.
  - pend_* = 0; led_state_up, led_state_dn and door_open = 0.
- Request latching (every clk, independent of tick):
  - pend |= masked button vector.
  - A press for the current floor while state=DOOR is not latched; instead cnt is reset to 0 on the next tick (door re-open).
- Serving a floor: on entering DOOR at floor f, pend_car[f], pend_up[f] and pend_dn[f] are cleared in that same cycle.
- Definitions: "above" = any pending bit at an index greater than the current floor; "below" = any at a lower index; "here" = any pending bit at the current floor.
- IDLE, on tick, first match wins:
  1. here or bt_door_open → DOOR.
  2. above → MOVE_UP, dir=up.
  3. below → MOVE_DN, dir=dn.
  4. Otherwise remain IDLE.
- MOVE_UP / MOVE_DN, on tick:
  - The move counter increments. When it equals MOVE_TICKS-1, floor shifts one position up or down and the counter clears.
  - The arrival decision is evaluated on the new floor in that same tick. Stop (→ DOOR) if:
    - pend_car[new] is set; or
    - the hall call in the current direction at new is set; or
    - the opposite-direction hall call at new is set and nothing lies beyond new in the current direction.
  - Otherwise keep moving.
  - floor saturates at floor 1 and floor FLOORS; it never shifts past either end.
  - Door buttons are ignored while moving.
- DOOR, on tick:
  - cnt increments.
  - bt_door_open high at tick → cnt=0.
  - Exit when cnt==DOOR_TICKS-1 or bt_door_close=1 (close wins over open if both are high). On exit cnt=0 and the next state is:
    1. requests ahead in dir → move in dir;
    2. else requests behind → move the other way with dir flipped;
    3. else IDLE.
- All outputs are registered. state, floor and cnt change only on tick cycles or on reset.

Test Plan (FLOORS=8, DOOR_TICKS=5, MOVE_TICKS=2, tick every 4 clk):
- Reset, then press in_bt_floor[2] (floor 3) while at floor 1:
  - tick1 → MOVE_UP.
  - tick3 → floor=00000010.
  - tick5 → floor=00000100, state=DOOR, pend_car=0.
  - tick10 → IDLE.
- At floor 1, latch btdn[4] and in_bt_floor[6]:
  - The car passes floor 5 without stopping.
  - It stops at floor 7, then reverses (led_state_dn=1) and stops at floor 5.
- In DOOR at floor 3, press bt_door_open at the tick where cnt=3 → cnt=0 and the door stays open 5 more ticks.
- bt_door_close at the first DOOR tick → exit on that tick, cnt=0.
- Hall call btup[2] pressed while DOOR at floor 3 → pend_up stays 0 and cnt restarts. Pressing btup[7] and btdn[0] has no effect (pend remains 0).
- Assert rst mid-MOVE_UP at floor 4 with tick=1 → next clk: floor=1, state=IDLE, all pend_*=0, cnt=0.
